scan_scheduler: RTL and testbench

SCAN_SCHEDULER -- requirements
Module: scan_scheduler

---
 rtl/scan_scheduler.sv | 154 +++++++++++++++
 tb/tb_scan_scheduler.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/scan_scheduler.sv
`timescale 1ns/1ps
// Scan scheduler: walks one LiDAR scan beam by beam, skips out-of-range samples
// and hands each valid beam (range, angle) to a busy/start handshaked ray tracer.
module scan_scheduler #(
  parameter int unsigned N_BEAMS = 360,
  parameter int unsigned ADDR_W  = 9
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              scan_start,
  input  logic [31:0]       angle_min,
  input  logic [31:0]       angle_step,
  input  logic [31:0]       range_max,
  output logic [ADDR_W-1:0] scan_addr,
  input  logic [31:0]       scan_rdata,
  input  logic              bres_busy,
  output logic              bres_start,
  output logic [31:0]       bres_magnitude,
  output logic [31:0]       bres_angle,
  output logic              busy,
  output logic              scan_done,
  output logic [ADDR_W:0]   beams_traced
);

  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned DATA_W = 32;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_CHECK   = 3'd2;
  localparam logic [2:0] S_LAUNCH  = 3'd3;
  localparam logic [2:0] S_WAIT_HI = 3'd4;
  localparam logic [2:0] S_WAIT_LO = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  logic [2:0]        r_state,  w_state;
  logic [ADDR_W-1:0] r_idx,    w_idx;
  logic              r_start,  w_start;
  logic [DATA_W-1:0] r_mag,    w_mag;
  logic [DATA_W-1:0] r_angle,  w_angle;
  logic              r_busy,   w_busy;
  logic              r_done,   w_done;
  logic [CNT_W-1:0]  r_traced, w_traced;
  logic [DATA_W-1:0] r_step,   w_step;
  logic [DATA_W-1:0] r_rmax,   w_rmax;

  logic w_valid;
  logic w_last;
  logic w_advance;

  assign w_valid = (scan_rdata != '0) && (scan_rdata <= r_rmax);
  assign w_last  = (r_idx == ADDR_W'(N_BEAMS - 1));

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    w_state   = r_state;
    w_idx     = r_idx;
    w_start   = 1'b0;
    w_mag     = r_mag;
    w_angle   = r_angle;
    w_busy    = r_busy;
    w_done    = 1'b0;
    w_traced  = r_traced;
    w_step    = r_step;
    w_rmax    = r_rmax;
    w_advance = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (scan_start) begin
          w_angle  = angle_min;
          w_step   = angle_step;
          w_rmax   = range_max;
          w_idx    = '0;
          w_traced = '0;
          w_busy   = 1'b1;
          w_state  = S_FETCH;
        end
      end
      S_FETCH: w_state = S_CHECK;
      S_CHECK: begin
        if (w_valid) begin
          w_mag   = scan_rdata;
          w_state = S_LAUNCH;
        end else begin
          w_advance = 1'b1;
        end
      end
      S_LAUNCH: begin
        if (!bres_busy) begin
          w_start  = 1'b1;
          w_traced = r_traced + CNT_W'(1);
          w_state  = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        if (bres_busy) w_state = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (!bres_busy) w_advance = 1'b1;
      end
      S_DONE:  w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase

    // Shared beam-advance step for skipped and completed beams.
    if (w_advance) begin
      if (w_last) begin
        w_done  = 1'b1;
        w_busy  = 1'b0;
        w_state = S_DONE;
      end else begin
        w_idx   = r_idx + ADDR_W'(1);
        w_angle = r_angle + r_step;
        w_state = S_FETCH;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_start  <= 1'b0;
      r_mag    <= '0;
      r_angle  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_traced <= '0;
      r_step   <= '0;
      r_rmax   <= '0;
    end else begin
      r_state  <= w_state;
      r_idx    <= w_idx;
      r_start  <= w_start;
      r_mag    <= w_mag;
      r_angle  <= w_angle;
      r_busy   <= w_busy;
      r_done   <= w_done;
      r_traced <= w_traced;
      r_step   <= w_step;
      r_rmax   <= w_rmax;
    end
  end

  assign scan_addr      = r_idx;
  assign bres_start     = r_start;
  assign bres_magnitude = r_mag;
  assign bres_angle     = r_angle;
  assign busy           = r_busy;
  assign scan_done      = r_done;
  assign beams_traced   = r_traced;

endmodule

// File: tb/tb_scan_scheduler.sv
`timescale 1ns/1ps
// Directed bench for scan_scheduler: 4-beam scans against a registered scan memory
// and a ray-tracer model that stays busy for 3 cycles after each start.
module tb_scan_scheduler;

  localparam int unsigned NB = 4;
  localparam int unsigned AW = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          scan_start = 1'b0;
  logic [31:0]   angle_min = '0;
  logic [31:0]   angle_step = '0;
  logic [31:0]   range_max = '0;
  logic [AW-1:0] scan_addr;
  logic [31:0]   scan_rdata = '0;
  logic          bres_busy;
  logic          bres_start;
  logic [31:0]   bres_magnitude;
  logic [31:0]   bres_angle;
  logic          busy;
  logic          scan_done;
  logic [AW:0]   beams_traced;

  logic [31:0] mem [NB];
  int          tr_cnt = 0;
  logic        tb_hold = 1'b0;

  logic [31:0] q_ang [$];
  logic [31:0] q_mag [$];
  int          n_done = 0;
  int          n_viol = 0;

  int n_cmp = 0;
  int n_fail = 0;

  scan_scheduler #(.N_BEAMS(NB), .ADDR_W(AW)) dut (
    .clock(clock), .reset(reset), .scan_start(scan_start),
    .angle_min(angle_min), .angle_step(angle_step), .range_max(range_max),
    .scan_addr(scan_addr), .scan_rdata(scan_rdata), .bres_busy(bres_busy),
    .bres_start(bres_start), .bres_magnitude(bres_magnitude), .bres_angle(bres_angle),
    .busy(busy), .scan_done(scan_done), .beams_traced(beams_traced)
  );

  always #5 clock = ~clock;

  // One-cycle read latency scan memory and 3-cycle busy ray tracer.
  always @(posedge clock) begin
    scan_rdata <= mem[scan_addr[1:0]];
    if (bres_start) tr_cnt <= 3;
    else if (tr_cnt > 0) tr_cnt <= tr_cnt - 1;
  end
  assign bres_busy = (tr_cnt != 0) || tb_hold;

  always @(negedge clock) begin
    if (bres_start) begin
      q_ang.push_back(bres_angle);
      q_mag.push_back(bres_magnitude);
      if (bres_busy) n_viol++;
    end
    if (scan_done) n_done++;
  end

  task automatic set_mem(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] d);
    mem[0] = a; mem[1] = b; mem[2] = c; mem[3] = d;
  endtask

  task automatic start_scan();
    @(negedge clock); scan_start = 1'b1;
    @(negedge clock); scan_start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clock);
      if (scan_done) begin ok = 1'b1; break; end
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    n_cmp++; if (scan_addr !== '0) begin n_fail++; $display("FAIL reset_addr got %h want 0", scan_addr); end
    n_cmp++; if (bres_start !== 1'b0) begin n_fail++; $display("FAIL reset_start got %b want 0", bres_start); end
    n_cmp++; if (bres_angle !== '0 || bres_magnitude !== '0) begin n_fail++; $display("FAIL reset_beam got %h/%h want 0/0", bres_angle, bres_magnitude); end
    n_cmp++; if (busy !== 1'b0 || scan_done !== 1'b0) begin n_fail++; $display("FAIL reset_flags got %b%b want 00", busy, scan_done); end
    n_cmp++; if (beams_traced !== '0) begin n_fail++; $display("FAIL reset_traced got %0d want 0", beams_traced); end
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_basic();
    bit ok;
    int b0, d0;
    logic [31:0] exp_ang [4];
    exp_ang[0] = 32'h100; exp_ang[1] = 32'h110; exp_ang[2] = 32'h120; exp_ang[3] = 32'h130;
    b0 = q_ang.size(); d0 = n_done;
    set_mem(50, 50, 50, 50);
    angle_min = 32'h100; angle_step = 32'h10; range_max = 100;
    start_scan();
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %b want 1", busy); end
    // configuration must be latched at acceptance
    angle_min = 32'hDEAD0000; angle_step = 32'h5555; range_max = 1;
    wait_done(ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL basic_timeout got no scan_done want scan_done"); end
    n_cmp++; if (q_ang.size() - b0 !== 4) begin n_fail++; $display("FAIL basic_launches got %0d want 4", q_ang.size() - b0); end
    for (int i = 0; i < 4 && b0 + i < q_ang.size(); i++) begin
      n_cmp++; if (q_ang[b0+i] !== exp_ang[i]) begin n_fail++; $display("FAIL basic_angle%0d got %h want %h", i, q_ang[b0+i], exp_ang[i]); end
      n_cmp++; if (q_mag[b0+i] !== 32'd50) begin n_fail++; $display("FAIL basic_mag%0d got %0d want 50", i, q_mag[b0+i]); end
    end
    n_cmp++; if (n_done - d0 !== 1) begin n_fail++; $display("FAIL basic_done got %0d want 1", n_done - d0); end
    n_cmp++; if (beams_traced !== 5'd4) begin n_fail++; $display("FAIL basic_traced got %0d want 4", beams_traced); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end got %b want 0", busy); end
  endtask

  task automatic test_skip();
    bit ok;
    int b0;
    b0 = q_ang.size();
    set_mem(0, 200, 30, 100);
    angle_min = 32'h100; angle_step = 32'h10; range_max = 100;
    start_scan();
    wait_done(ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL skip_timeout got no scan_done want scan_done"); end
    n_cmp++; if (q_ang.size() - b0 !== 2) begin n_fail++; $display("FAIL skip_launches got %0d want 2", q_ang.size() - b0); end
    if (q_ang.size() - b0 >= 2) begin
      n_cmp++; if (q_ang[b0] !== 32'h120 || q_mag[b0] !== 32'd30) begin n_fail++; $display("FAIL skip_beam2 got %h/%0d want 120/30", q_ang[b0], q_mag[b0]); end
      n_cmp++; if (q_ang[b0+1] !== 32'h130 || q_mag[b0+1] !== 32'd100) begin n_fail++; $display("FAIL skip_beam3 got %h/%0d want 130/100", q_ang[b0+1], q_mag[b0+1]); end
    end
    n_cmp++; if (beams_traced !== 5'd2) begin n_fail++; $display("FAIL skip_traced got %0d want 2", beams_traced); end
  endtask

  task automatic test_wrap();
    bit ok;
    int b0;
    b0 = q_ang.size();
    set_mem(50, 50, 50, 50);
    angle_min = 32'hFFFFFFF0; angle_step = 32'h10; range_max = 100;
    start_scan();
    wait_done(ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL wrap_timeout got no scan_done want scan_done"); end
    n_cmp++; if (q_ang.size() - b0 !== 4) begin n_fail++; $display("FAIL wrap_launches got %0d want 4", q_ang.size() - b0); end
    if (q_ang.size() - b0 >= 4) begin
      n_cmp++; if (q_ang[b0] !== 32'hFFFFFFF0) begin n_fail++; $display("FAIL wrap_beam0 got %h want fffffff0", q_ang[b0]); end
      n_cmp++; if (q_ang[b0+1] !== 32'h0) begin n_fail++; $display("FAIL wrap_beam1 got %h want 00000000", q_ang[b0+1]); end
      n_cmp++; if (q_ang[b0+3] !== 32'h20) begin n_fail++; $display("FAIL wrap_beam3 got %h want 00000020", q_ang[b0+3]); end
    end
  endtask

  task automatic test_all_invalid();
    bit ok;
    int b0, d0;
    b0 = q_ang.size(); d0 = n_done;
    set_mem(0, 101, 32'hFFFFFFFF, 0);
    angle_min = 32'h0; angle_step = 32'h1; range_max = 100;
    start_scan();
    wait_done(ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL invalid_timeout got no scan_done want scan_done"); end
    n_cmp++; if (q_ang.size() - b0 !== 0) begin n_fail++; $display("FAIL invalid_launches got %0d want 0", q_ang.size() - b0); end
    n_cmp++; if (beams_traced !== '0) begin n_fail++; $display("FAIL invalid_traced got %0d want 0", beams_traced); end
    n_cmp++; if (n_done - d0 !== 1) begin n_fail++; $display("FAIL invalid_done got %0d want 1", n_done - d0); end
    n_cmp++; if (bres_angle !== 32'h3) begin n_fail++; $display("FAIL invalid_angle got %h want 3", bres_angle); end
  endtask

  task automatic test_busy_hold();
    bit ok;
    int b0;
    b0 = q_ang.size();
    set_mem(50, 0, 0, 0);
    angle_min = 32'h40; angle_step = 32'h4; range_max = 100;
    tb_hold = 1'b1;
    start_scan();
    repeat (3) @(negedge clock);
    n_cmp++; if (q_ang.size() - b0 !== 0) begin n_fail++; $display("FAIL hold_early got %0d launches want 0", q_ang.size() - b0); end
    tb_hold = 1'b0;
    wait_done(ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL hold_timeout got no scan_done want scan_done"); end
    n_cmp++; if (q_ang.size() - b0 !== 1) begin n_fail++; $display("FAIL hold_launches got %0d want 1", q_ang.size() - b0); end
    n_cmp++; if (n_viol !== 0) begin n_fail++; $display("FAIL hold_start_while_busy got %0d want 0", n_viol); end
  endtask

  task automatic test_abort();
    bit ok, seen;
    int d0;
    d0 = n_done;
    set_mem(50, 50, 50, 50);
    angle_min = 32'h200; angle_step = 32'h8; range_max = 100;
    start_scan();
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clock);
      if (bres_busy) begin seen = 1'b1; break; end
    end
    n_cmp++; if (!seen) begin n_fail++; $display("FAIL abort_no_launch got busy=0 want busy=1"); end
    scan_start = 1'b1;
    @(negedge clock);
    scan_start = 1'b0;
    n_cmp++; if (beams_traced !== 5'd1 || busy !== 1'b1) begin n_fail++; $display("FAIL abort_restart_ignored got %0d/%b want 1/1", beams_traced, busy); end
    reset = 1'b0;
    @(negedge clock);
    n_cmp++; if (bres_start !== 1'b0) begin n_fail++; $display("FAIL abort_start_in_reset got %b want 0", bres_start); end
    @(negedge clock);
    n_cmp++; if ({scan_addr, bres_angle, bres_magnitude, busy, scan_done, beams_traced} !== '0) begin
      n_fail++; $display("FAIL abort_outputs got %h/%h/%h/%b/%b/%0d want all 0", scan_addr, bres_angle, bres_magnitude, busy, scan_done, beams_traced);
    end
    reset = 1'b1;
    repeat (6) @(negedge clock);
    n_cmp++; if (n_done !== d0 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_no_done got %0d/%b want %0d/0", n_done, busy, d0); end
    start_scan();
    wait_done(ok);
    n_cmp++; if (!ok || beams_traced !== 5'd4) begin n_fail++; $display("FAIL abort_rescan got %b/%0d want 1/4", ok, beams_traced); end
  endtask

  initial begin
    set_mem(0, 0, 0, 0);
    test_reset();
    test_basic();
    test_skip();
    test_wrap();
    test_all_invalid();
    test_busy_hold();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
